// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access size codes, FSM states
// and the size-to-byte-count helper.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } lsuState_t;

  // Number of bytes touched by an access of the given size code.
  function automatic int unsigned bytes_of(input logic [1:0] size);
    return 32'd1 << size;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Big-endian lane steering: byte enables and store placement for the request
// path, lane extraction plus sign/zero extension for the load return path.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]                  size,
  input  logic [$clog2(DATA_W/8)-1:0] offset,
  input  logic                        sgnExt,
  input  logic [DATA_W-1:0]           storeData,
  input  logic [DATA_W-1:0]           memWord,
  output logic [DATA_W/8-1:0]         byteEn,
  output logic [DATA_W-1:0]           laneData,
  output logic [DATA_W-1:0]           loadData
);

  localparam int NB = DATA_W / 8;

  int                nBytes;
  int                lowLane;
  logic [DATA_W-1:0] sizeMask;
  logic [DATA_W-1:0] extracted;
  logic              signBit;

  // Offset 0 is the MSB lane, so the access ends at lane NB-offset-size.
  always_comb begin
    nBytes = int'(bytes_of(size));
    if (nBytes > NB) nBytes = NB;
    lowLane = NB - int'(offset) - nBytes;
    if (lowLane < 0) lowLane = 0;
    sizeMask  = (DATA_W'(1) << (8 * nBytes)) - DATA_W'(1);
    byteEn    = ((NB'(1) << nBytes) - NB'(1)) << lowLane;
    laneData  = (storeData & sizeMask) << (8 * lowLane);
    extracted = (memWord >> (8 * lowLane)) & sizeMask;
    signBit   = |(extracted & (DATA_W'(1) << (8 * nBytes - 1)));
    loadData  = (sgnExt && signBit) ? (extracted | ~sizeMask) : extracted;
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: accepts one access from EX, drives a
// variable-latency req/ack memory port with timeout, returns one response.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wr,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  lsuState_t         state;
  lsuState_t         stateNext;
  logic [CNT_W-1:0]  waitCnt;
  logic [1:0]        latSize;
  logic              latSigned;
  logic              latWr;
  logic [OFF_W-1:0]  latOffset;
  logic [OFF_W-1:0]  reqOffset;
  logic              reqBad;
  logic              timeoutHit;
  logic [1:0]        alSize;
  logic [OFF_W-1:0]  alOffset;
  logic [NB-1:0]     alBe;
  logic [DATA_W-1:0] alWdata;
  logic [DATA_W-1:0] alLoad;

  assign reqOffset = req_addr[OFF_W-1:0];

  // Reject illegal sizes and addresses that are not a multiple of the size.
  always_comb begin
    reqBad = ((req_size == SZ_DWORD) && (DATA_W != 64)) ||
             ((reqOffset & OFF_W'(bytes_of(req_size) - 1)) != '0);
  end

  // One aligner serves both paths: live request fields while idle, latched
  // fields while waiting for the load data to come back.
  always_comb begin
    alSize   = (state == IDLE) ? req_size  : latSize;
    alOffset = (state == IDLE) ? reqOffset : latOffset;
  end

  lsu_lane_align #(
    .DATA_W(DATA_W)
  ) uAlign (
    .size     (alSize),
    .offset   (alOffset),
    .sgnExt   (latSigned),
    .storeData(req_wdata),
    .memWord  (mem_rdata),
    .byteEn   (alBe),
    .laneData (alWdata),
    .loadData (alLoad)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  // Next-state decode; an ack in the last allowed cycle beats the timeout.
  always_comb begin
    stateNext  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    timeoutHit = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) stateNext = reqBad ? RESP : WAIT;
      end
      WAIT: begin
        if (mem_ack) begin
          stateNext = RESP;
        end else if ((TIMEOUT > 0) && (int'(waitCnt) == TIMEOUT - 1)) begin
          stateNext  = RESP;
          timeoutHit = 1'b1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        stateNext  = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Request latching, memory port registers and response capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      waitCnt    <= '0;
      latSize    <= SZ_BYTE;
      latSigned  <= 1'b0;
      latWr      <= 1'b0;
      latOffset  <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            latSize   <= req_size;
            latSigned <= req_signed;
            latWr     <= req_wr;
            latOffset <= reqOffset;
            waitCnt   <= '0;
            if (reqBad) begin
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= req_wr;
              mem_addr  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              mem_be    <= alBe;
              mem_wdata <= alWdata;
            end
          end
        end
        WAIT: begin
          waitCnt <= waitCnt + 1'b1;
          if (mem_ack) begin
            mem_req    <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= latWr ? '0 : alLoad;
          end else if (timeoutHit) begin
            mem_req    <= 1'b0;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: a driver issues accesses and plays the
// memory, a monitor checks memory requests and responses against the model.
module tb_lsu_mem_stage;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  lsu_mem_stage #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          at;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    int          len;
  } memreq_t;

  resp_t   respQ[$];
  memreq_t memQ[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: walk the accessed bytes in address order; byte offset o sits
  // in bits 31-8o..24-8o of the memory word.
  function automatic void model(input logic wr, input logic [1:0] sz, input logic sg,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] rd, output logic isBad,
                                output logic [3:0] be, output logic [31:0] wp,
                                output logic [31:0] ld);
    int s;
    int o;
    int off;
    s = 1 << sz;
    o = int'(addr % 4);
    isBad = (sz == 2'b11) || ((addr % s) != 0);
    be = '0;
    wp = '0;
    ld = '0;
    if (!isBad) begin
      for (int i = 0; i < s; i++) begin
        off = o + i;
        be[3 - off] = 1'b1;
        wp[8 * (3 - off) +: 8] = wd[8 * (s - 1 - i) +: 8];
        ld = (ld << 8) | {24'h0, rd[8 * (3 - off) +: 8]};
      end
      if (sg && s < 4 && ((ld >> (8 * s - 1)) & 32'h1) == 32'h1)
        ld = ld | ~((32'h1 << (8 * s)) - 32'h1);
    end
    if (wr) ld = '0;
  endfunction

  // Monitor: memory request fields and length, response data/err/timing.
  memreq_t curM;
  resp_t   curR;
  bit      active = 0;
  bit      curValid = 0;
  int      runLen = 0;
  logic [31:0] lastR = '0;
  logic        lastE = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      active = 0;
      curValid = 0;
      runLen = 0;
      lastR = '0;
      lastE = 1'b0;
    end else begin
      if (resp_valid) begin
        if (respQ.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_resp: resp_valid=1 with nothing outstanding (cycle %0d)", cyc);
        end else begin
          curR = respQ.pop_front();
          chk("resp_rdata", resp_rdata, curR.rdata);
          chk("resp_err", resp_err, curR.err);
          chk("resp_cycle", cyc, curR.at);
        end
        lastR = resp_rdata;
        lastE = resp_err;
      end else begin
        chk("resp_rdata_hold", resp_rdata, lastR);
        chk("resp_err_hold", resp_err, lastE);
      end
      if (mem_req) begin
        if (!active) begin
          active = 1;
          runLen = 0;
          if (memQ.size() == 0) begin
            curValid = 0;
            total++; bad++;
            $display("FAIL unexpected_mem_req: mem_req=1 addr=%0h with none expected (cycle %0d)", mem_addr, cyc);
          end else begin
            curM = memQ.pop_front();
            curValid = 1;
          end
        end
        if (curValid) begin
          chk("mem_addr", mem_addr, curM.addr);
          chk("mem_be", mem_be, curM.be);
          chk("mem_we", mem_we, curM.we);
          if (curM.we) chk("mem_wdata", mem_wdata, curM.wdata);
        end
        runLen++;
      end else if (active) begin
        if (curValid) chk("mem_req_len", runLen, curM.len);
        active = 0;
        curValid = 0;
      end
    end
  end

  // Driver: issue one access, push expectations, then play the memory.
  // ackAt = mem_req cycle carrying the ack (0 = never); abortAt = mem_req
  // cycle in which reset is asserted (0 = never).
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input int ackAt, input int abortAt);
    int waitN;
    int acc;
    logic isBad;
    logic [3:0] be;
    logic [31:0] wp;
    logic [31:0] ld;
    resp_t r;
    memreq_t m;
    waitN = 0;
    while (!req_ready && waitN < 50) begin
      @(posedge clk); #1;
      waitN++;
    end
    if (!req_ready) begin
      total++; bad++;
      $display("FAIL req_ready_wait: req_ready=%0b want 1 within 50 cycles", req_ready);
      return;
    end
    req_valid = 1'b1; req_wr = wr; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    acc = cyc;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    req_size = 2'($urandom); req_wr = 1'($urandom); req_signed = 1'($urandom);
    model(wr, sz, sg, addr, wd, rd, isBad, be, wp, ld);
    if (isBad) begin
      r.rdata = '0; r.err = 1'b1; r.at = acc;
      respQ.push_back(r);
    end else begin
      m.addr = addr & ~32'h3; m.be = be; m.we = wr; m.wdata = wp;
      m.len = (ackAt == 0) ? TO : ackAt;
      memQ.push_back(m);
      r.rdata = (ackAt == 0) ? 32'h0 : ld;
      r.err = (ackAt == 0);
      r.at = acc + m.len;
      respQ.push_back(r);
      for (int j = 1; j <= m.len; j++) begin
        if (j == abortAt) begin
          #2 rst = 1'b0;
          #1;
          chk("rst_mem_req", mem_req, 0);
          chk("rst_resp_valid", resp_valid, 0);
          chk("rst_req_ready", req_ready, 1);
          chk("rst_mem_addr", mem_addr, 0);
          chk("rst_mem_be", mem_be, 0);
          respQ.delete();
          memQ.delete();
          repeat (3) @(posedge clk);
          #1 rst = 1'b1;
          return;
        end
        mem_ack = (j == ackAt);
        mem_rdata = (j == ackAt) ? rd : $urandom;
        @(posedge clk); #1;
      end
      mem_ack = 1'b0;
    end
    // Response cycle: a stray ack here must be ignored.
    mem_ack = 1'($urandom);
    mem_rdata = $urandom;
    @(posedge clk); #1;
    mem_ack = 1'b0;
  endtask

  initial begin
    logic [1:0] rsz;
    int ack;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", req_ready, 1);
    chk("reset_mem_req", mem_req, 0);
    chk("reset_resp_valid", resp_valid, 0);
    chk("reset_mem_we", mem_we, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_mem_be", mem_be, 0);
    chk("reset_mem_wdata", mem_wdata, 0);
    chk("reset_resp_rdata", resp_rdata, 0);
    chk("reset_resp_err", resp_err, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    issue(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h112233F4, 1, 0);
    issue(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000ABCD, 32'h5A5A5A5A, 2, 0);
    issue(1'b0, 2'b01, 1'b0, 32'h100, 32'h0, 32'h8001FFFF, 1, 0);
    issue(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h0, 1, 0);
    issue(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'h0, 1, 0);
    issue(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 32'hCAFEF00D, 0, 0);
    issue(1'b0, 2'b10, 1'b1, 32'h108, 32'h0, 32'h87654321, TO, 0);
    issue(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'h13572468, 3, 2);
    @(posedge clk); #1;
    chk("post_rst_req_ready", req_ready, 1);
    issue(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'h2468ACE0, 2, 0);

    for (int n = 0; n < 120; n++) begin
      rsz = 2'($urandom_range(0, 3));
      ack = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TO);
      issue(1'($urandom), rsz, 1'($urandom), $urandom, $urandom, $urandom, ack, 0);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("resp_outstanding", respQ.size(), 0);
    chk("memreq_outstanding", memQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Parametrised load/store unit replacing the pass-through MEM stage of the single-cycle datapath.
- Accepts one load/store per handshake from EX and aligns addresses to words.
- Generates byte enables and lane-shifts store data. Extracts and sign/zero-extends load data.
- Talks to data memory over a variable-latency req/ack interface with timeout.
- Stalls the core via req_ready.

Parameters:
- DATA_W, 32, memory word width in bits; legal values 32 or 64.
- ADDR_W, 32, byte address width.
- TIMEOUT, 16, max WAIT cycles before an error response; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  EX presents an access.
- req_ready  out  1  LSU can accept; low = stall the core.
- req_wr  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 dword (legal only when DATA_W=64).
- req_signed  in  1  load sign-extends when 1.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned, illegal size or timeout; valid with resp_valid.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  word-aligned address; low log2(DATA_W/8) bits are 0.
- mem_be  out  DATA_W/8  byte enables; bit k = byte lane k (bits 8k+7:8k).
- mem_wdata  out  DATA_W  lane-placed store data; unused lanes are 0.
- mem_ack  in  1  memory completes; mem_rdata is valid this cycle for loads.
- mem_rdata  in  DATA_W  read word.

Behaviour:
- Reset (rst=0, async): state IDLE, timeout counter 0, all outputs 0 except req_ready=1. mem_req drops immediately. A transaction in flight is abandoned with no response.
- Byte ordering is big-endian. Offset 0 is the most significant byte. Offset o of a size-s access (s bytes) occupies bits DATA_W-1-8o down to DATA_W-8(o+s).
- State IDLE:
  - req_ready=1.
  - On req_valid: latch all req_* fields.
  - If req_addr is not a multiple of the access size, or req_size is illegal: go RESP with err=1. mem_req is never asserted.
  - Otherwise: go WAIT. mem_req, mem_we, mem_addr, mem_be and mem_wdata are registered and valid from the next cycle.
- State WAIT:
  - req_ready=0. mem_* outputs held stable.
  - Counter increments every WAIT cycle.
  - On mem_ack: capture mem_rdata, extract the lane and extend to DATA_W, then go RESP with err=0. mem_req is 0 the cycle after ack.
  - If TIMEOUT>0 and the counter reaches TIMEOUT with no ack: drop mem_req and go RESP with err=1.
  - mem_ack in the final timeout cycle wins; the access completes normally.
- State RESP:
  - resp_valid=1 for exactly one cycle; req_ready=0; next state IDLE.
  - resp_rdata and resp_err hold their value until the next RESP.
- Latency: accept in cycle N → mem_req high in N+1 → ack in cycle M (M ≥ N+1) → resp_valid in M+1. Minimum 2 cycles accept-to-resp. Minimum 3 cycles between accepts.
- mem_ack while in IDLE or RESP is ignored.
- req_valid while req_ready=0 is ignored; EX holds it.
- Stores return resp_rdata=0.
- Loads with req_signed=0 zero-extend.

Decomposition:
- Shared package lsu_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD;
  - state enum IDLE, WAIT, RESP;
  - function bytes_of(size).
- One combinational sub-module, lsu_lane_align, does be generation, store lane placement, load extraction and extension. It is reused for both paths.

Test Plan:
- Signed load byte, addr 0x103, mem_rdata 0x112233F4, ack in the first mem_req cycle → mem_addr 0x100, mem_be 0001, resp_rdata 0xFFFFFFF4, resp_err 0, resp_valid 2 cycles after accept.
- Store half, addr 0x202, req_wdata 0x0000ABCD → mem_we 1, mem_addr 0x200, mem_be 0011, mem_wdata 0x0000ABCD, resp_rdata 0.
- Unsigned load half, addr 0x100, mem_rdata 0x8001FFFF → mem_be 1100, resp_rdata 0x00008001.
- Misaligned word load, addr 0x102 → mem_req stays 0, resp_valid the cycle after accept with resp_err 1. Also size 11 with DATA_W=32 → same result.
- TIMEOUT=8, no ack → mem_req high for exactly 8 cycles, then resp_err 1. Repeat with ack in the 8th cycle → resp_err 0 and data returned.
- Assert rst mid-WAIT with ack delayed 3 cycles → mem_req 0 immediately, no resp_valid. After release, req_ready 1 and a new word load completes correctly.
